// File: rtl/audio_i2s_rx.sv
// -----------------------------------------------------------------------------
// audio_i2s_rx
//
// Receive-side I2S deserializer. The external BCLK/LRCLK/SDATA lines are
// oversampled with the system clock, MSB-first channel words are reassembled,
// and each completed left/right pair is presented as parallel samples with a
// one-cycle valid strobe.
//
// Parameters
//   SAMPLE_W      bits kept per channel word (8..24)
//
// Ports
//   clk           system clock, at least 4x BCLK
//   rst           asynchronous, active-high reset
//   en            receiver enable; low clears lock, counters and error state
//   i2s_bclk      serial bit clock (asynchronous)
//   i2s_lrclk     word select, 0 = left, 1 = right (asynchronous)
//   i2s_sdata     serial data, MSB first (asynchronous)
//   left_sample   last completed left word
//   right_sample  last completed right word
//   sample_valid  one-cycle pulse, both sample outputs updated this cycle
//   frame_err     one-cycle pulse, the completed word was short
//   locked        first LRCLK transition seen since reset or en rise
// -----------------------------------------------------------------------------
module audio_i2s_rx #(
   parameter int SAMPLE_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                i2s_bclk,
   input  logic                i2s_lrclk,
   input  logic                i2s_sdata,
   output logic [SAMPLE_W-1:0] left_sample,
   output logic [SAMPLE_W-1:0] right_sample,
   output logic                sample_valid,
   output logic                frame_err,
   output logic                locked
);

   localparam logic ST_UNLOCKED = 1'b0;
   localparam logic ST_LOCKED   = 1'b1;

   localparam logic [5:0]          CNT_MAX    = 6'd63;
   localparam logic [5:0]          SAMPLE_W_C = 6'(SAMPLE_W);
   localparam logic [SAMPLE_W-1:0] MSB_ONE    = {1'b1, {(SAMPLE_W-1){1'b0}}};

   // Input synchronizers (2 FF each) plus the bclk edge-detect delay stage.
   logic bclk_s1_q, bclk_s_q, bclk_d_q;
   logic lrclk_s1_q, lrclk_s_q;
   logic sdata_s1_q, sdata_s_q;

   // Receiver state
   logic                state_q,        state_d;
   logic                lr_prev_q,      lr_prev_d;
   logic [5:0]          bit_cnt_q,      bit_cnt_d;
   logic [SAMPLE_W-1:0] shreg_q,        shreg_d;
   logic                have_left_q,    have_left_d;
   logic [SAMPLE_W-1:0] left_hold_q,    left_hold_d;
   logic [SAMPLE_W-1:0] left_sample_q,  left_sample_d;
   logic [SAMPLE_W-1:0] right_sample_q, right_sample_d;
   logic                sample_valid_q, sample_valid_d;
   logic                frame_err_q,    frame_err_d;

   logic                bclk_rise;
   logic [SAMPLE_W-1:0] word;

   assign bclk_rise = bclk_s_q & ~bclk_d_q;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would infer a latch.
      state_d        = state_q;
      lr_prev_d      = lr_prev_q;
      bit_cnt_d      = bit_cnt_q;
      shreg_d        = shreg_q;
      have_left_d    = have_left_q;
      left_hold_d    = left_hold_q;
      left_sample_d  = left_sample_q;
      right_sample_d = right_sample_q;
      sample_valid_d = 1'b0;
      frame_err_d    = 1'b0;
      word           = shreg_q;

      if (!en) begin
         // Disabled: drop lock and any partial word, but hold the outputs.
         state_d     = ST_UNLOCKED;
         have_left_d = 1'b0;
         bit_cnt_d   = 6'd0;
         shreg_d     = '0;
      end else if (bclk_rise) begin
         // Bit position SAMPLE_W-1-bit_cnt; once bit_cnt reaches SAMPLE_W the
         // shifted mask is all-zero, so extra LSBs fall away and MSBs are kept.
         if (sdata_s_q && (bit_cnt_q < SAMPLE_W_C)) begin
            word = shreg_q | (MSB_ONE >> bit_cnt_q);
         end
         shreg_d   = word;
         bit_cnt_d = (bit_cnt_q == CNT_MAX) ? CNT_MAX : bit_cnt_q + 6'd1;

         // LRCLK leads the data by one bit, so a change in word select marks
         // the bit just stored as the LSB of channel lr_prev.
         if (lrclk_s_q != lr_prev_q) begin
            shreg_d   = '0;
            bit_cnt_d = 6'd0;
            lr_prev_d = lrclk_s_q;

            if (state_q == ST_UNLOCKED) begin
               state_d = ST_LOCKED;
            end else begin
               // Word length including the final bit is bit_cnt_q + 1.
               frame_err_d = (bit_cnt_q < SAMPLE_W_C - 6'd1);
               if (!lr_prev_q) begin
                  left_hold_d = word;
                  have_left_d = 1'b1;
               end else if (have_left_q) begin
                  left_sample_d  = left_hold_q;
                  right_sample_d = word;
                  sample_valid_d = 1'b1;
                  have_left_d    = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bclk_s1_q      <= 1'b0;
         bclk_s_q       <= 1'b0;
         bclk_d_q       <= 1'b0;
         lrclk_s1_q     <= 1'b0;
         lrclk_s_q      <= 1'b0;
         sdata_s1_q     <= 1'b0;
         sdata_s_q      <= 1'b0;
         state_q        <= ST_UNLOCKED;
         lr_prev_q      <= 1'b0;
         bit_cnt_q      <= 6'd0;
         shreg_q        <= '0;
         have_left_q    <= 1'b0;
         left_hold_q    <= '0;
         left_sample_q  <= '0;
         right_sample_q <= '0;
         sample_valid_q <= 1'b0;
         frame_err_q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so the synchronizer chain shifts by
         // exactly one stage per clock regardless of statement order.
         bclk_s1_q      <= i2s_bclk;
         bclk_s_q       <= bclk_s1_q;
         bclk_d_q       <= bclk_s_q;
         lrclk_s1_q     <= i2s_lrclk;
         lrclk_s_q      <= lrclk_s1_q;
         sdata_s1_q     <= i2s_sdata;
         sdata_s_q      <= sdata_s1_q;
         state_q        <= state_d;
         lr_prev_q      <= lr_prev_d;
         bit_cnt_q      <= bit_cnt_d;
         shreg_q        <= shreg_d;
         have_left_q    <= have_left_d;
         left_hold_q    <= left_hold_d;
         left_sample_q  <= left_sample_d;
         right_sample_q <= right_sample_d;
         sample_valid_q <= sample_valid_d;
         frame_err_q    <= frame_err_d;
      end
   end

   assign left_sample  = left_sample_q;
   assign right_sample = right_sample_q;
   assign sample_valid = sample_valid_q;
   assign frame_err    = frame_err_q;
   assign locked       = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_audio_i2s_rx.sv
// -----------------------------------------------------------------------------
// tb_audio_i2s_rx
//
// Self-checking bench for audio_i2s_rx (SAMPLE_W = 16, clk = 8x BCLK).
// Slot-width vectors come from a table; expected sample pairs go into a
// scoreboard queue as frames are queued for transmission and are popped by a
// monitor on every sample_valid. Hand-written sequences cover starting on the
// right slot, en dropping mid-word and reset asserted mid-word.
// -----------------------------------------------------------------------------
module tb_audio_i2s_rx;

   localparam int SW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          i2s_bclk;
   logic          i2s_lrclk;
   logic          i2s_sdata;
   logic [SW-1:0] left_sample;
   logic [SW-1:0] right_sample;
   logic          sample_valid;
   logic          frame_err;
   logic          locked;

   always #5 clk = ~clk;

   audio_i2s_rx #(.SAMPLE_W(SW)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .i2s_bclk     (i2s_bclk),
      .i2s_lrclk    (i2s_lrclk),
      .i2s_sdata    (i2s_sdata),
      .left_sample  (left_sample),
      .right_sample (right_sample),
      .sample_valid (sample_valid),
      .frame_err    (frame_err),
      .locked       (locked)
   );

   typedef struct {
      int            slot_w;
      logic [23:0]   left;
      logic [23:0]   right;
      logic [SW-1:0] exp_l;
      logic [SW-1:0] exp_r;
      bit            short_slot;
   } vec_t;

   typedef struct {
      logic [SW-1:0] l;
      logic [SW-1:0] r;
   } pair_t;

   pair_t         sb[$];
   bit            ch_q[$];
   bit            d_q[$];
   int            tests      = 0;
   int            fails      = 0;
   int            valid_seen = 0;
   int            err_seen   = 0;
   logic [SW-1:0] prev_l     = '0;
   logic [SW-1:0] prev_r     = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor, sampling on the falling clk edge.
   always @(negedge clk) begin
      pair_t p;
      if (sample_valid === 1'b1) begin
         valid_seen++;
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_valid: got 1, expected 0 (no pair pending)");
         end else begin
            p = sb.pop_front();
            check("left_sample", 32'(left_sample), 32'(p.l));
            check("right_sample", 32'(right_sample), 32'(p.r));
         end
      end
      if (frame_err === 1'b1) err_seen++;
      if (rst === 1'b0 && sample_valid !== 1'b1 &&
          (left_sample !== prev_l || right_sample !== prev_r)) begin
         tests++;
         fails++;
         $display("FAIL held_outputs: got %h/%h, expected %h/%h", left_sample, right_sample, prev_l, prev_r);
      end
      prev_l = left_sample;
      prev_r = right_sample;
   end

   // One BCLK period: 4 clk low (lrclk/sdata set up), 4 clk high.
   task automatic send_bit(input bit lr, input bit d);
      @(negedge clk);
      i2s_bclk  = 1'b0;
      i2s_lrclk = lr;
      i2s_sdata = d;
      repeat (4) @(negedge clk);
      i2s_bclk = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic add_word(input bit ch, input logic [23:0] v, input int w);
      for (int i = w - 1; i >= 0; i--) begin
         ch_q.push_back(ch);
         d_q.push_back(v[i]);
      end
   endtask

   // LRCLK for bit i is the channel of bit i+1 (one-bit I2S delay); after the
   // stream ends LRCLK returns to left, which completes the last right word.
   task automatic send_range(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         send_bit((i + 1 < ch_q.size()) ? ch_q[i + 1] : 1'b0, d_q[i]);
      end
   endtask

   task automatic clear_stream();
      ch_q.delete();
      d_q.delete();
   endtask

   task automatic push_pair(input logic [SW-1:0] l, input logic [SW-1:0] r);
      pair_t p;
      p.l = l;
      p.r = r;
      sb.push_back(p);
   endtask

   vec_t vecs[7];

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base_v;
      int base_e;

      vecs[0] = '{16, 24'h00A55A, 24'h001234, 16'hA55A, 16'h1234, 1'b0};
      vecs[1] = '{24, 24'hABCDEF, 24'h123456, 16'hABCD, 16'h1234, 1'b0};
      vecs[2] = '{12, 24'h000FFF, 24'h000800, 16'hFFF0, 16'h8000, 1'b1};
      vecs[3] = '{16, 24'h00FFFF, 24'h000000, 16'hFFFF, 16'h0000, 1'b0};
      vecs[4] = '{16, 24'h008001, 24'h007FFE, 16'h8001, 16'h7FFE, 1'b0};
      vecs[5] = '{17, 24'h01FFFF, 24'h000001, 16'hFFFF, 16'h0000, 1'b0};
      vecs[6] = '{15, 24'h007FFF, 24'h004001, 16'hFFFE, 16'h8002, 1'b1};

      // Reset with inputs toggling
      rst = 1'b1;
      en  = 1'b1;
      i2s_bclk = 1'b0; i2s_lrclk = 1'b0; i2s_sdata = 1'b0;
      repeat (20) begin
         @(negedge clk);
         i2s_bclk  = 1'($urandom_range(0, 1));
         i2s_lrclk = 1'($urandom_range(0, 1));
         i2s_sdata = 1'($urandom_range(0, 1));
      end
      check("rst_left", 32'(left_sample), 32'h0);
      check("rst_right", 32'(right_sample), 32'h0);
      check("rst_valid", 32'(sample_valid), 32'h0);
      check("rst_frame_err", 32'(frame_err), 32'h0);
      check("rst_locked", 32'(locked), 32'h0);
      i2s_bclk = 1'b0; i2s_lrclk = 1'b0; i2s_sdata = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b1);
      check("locked_before_lr_edge", 32'(locked), 32'h0);

      // Table-driven slot widths: 3 frames each; frame 0 is lost to locking.
      for (int v = 0; v < 7; v++) begin
         en = 1'b0;
         repeat (5) @(negedge clk);
         check("locked_cleared", 32'(locked), 32'h0);
         base_v = valid_seen;
         base_e = err_seen;
         clear_stream();
         for (int f = 0; f < 3; f++) begin
            add_word(1'b0, vecs[v].left, vecs[v].slot_w);
            add_word(1'b1, vecs[v].right, vecs[v].slot_w);
            if (f > 0) push_pair(vecs[v].exp_l, vecs[v].exp_r);
         end
         en = 1'b1;
         send_range(0, ch_q.size());
         repeat (10) @(negedge clk);
         check("valid_count", 32'(valid_seen - base_v), 32'd2);
         // Short slots: dropped right of frame 0 plus both words of frames 1-2.
         check("frame_err_count", 32'(err_seen - base_e), vecs[v].short_slot ? 32'd5 : 32'd0);
         check("pairs_pending", 32'(sb.size()), 32'd0);
         check("locked_after_run", 32'(locked), 32'h1);
         sb.delete();
      end

      // Start on the right slot: LSB of a prior left word, then a right word
      // that must be dropped, then one full pair.
      en = 1'b0;
      repeat (5) @(negedge clk);
      clear_stream();
      add_word(1'b0, 24'h0, 1);
      add_word(1'b1, 24'h5555, 16);
      add_word(1'b0, 24'h1357, 16);
      add_word(1'b1, 24'h9BDF, 16);
      push_pair(16'h1357, 16'h9BDF);
      i2s_lrclk = ch_q[1];
      repeat (4) @(negedge clk);
      base_v = valid_seen;
      base_e = err_seen;
      en = 1'b1;
      send_range(0, ch_q.size());
      repeat (10) @(negedge clk);
      check("right_start_valid_count", 32'(valid_seen - base_v), 32'd1);
      check("right_start_frame_err", 32'(err_seen - base_e), 32'd0);
      sb.delete();

      // en dropped for 10 clk in the middle of a left word.
      clear_stream();
      add_word(1'b0, 24'h2468, 16);
      add_word(1'b1, 24'hACE0, 16);
      add_word(1'b0, 24'h1111, 16);
      add_word(1'b1, 24'h2222, 16);
      push_pair(16'h1111, 16'h2222);
      base_v = valid_seen;
      base_e = err_seen;
      send_range(0, 8);
      en = 1'b0;
      repeat (10) @(negedge clk);
      check("en_drop_locked", 32'(locked), 32'h0);
      check("en_drop_left_hold", 32'(left_sample), 32'h1357);
      check("en_drop_right_hold", 32'(right_sample), 32'h9BDF);
      check("en_drop_no_pulse", 32'(valid_seen - base_v), 32'd0);
      en = 1'b1;
      send_range(8, ch_q.size());
      repeat (10) @(negedge clk);
      check("en_drop_valid_count", 32'(valid_seen - base_v), 32'd1);
      check("en_drop_frame_err", 32'(err_seen - base_e), 32'd0);
      sb.delete();

      // Reset asserted mid left word, off the clock edge.
      clear_stream();
      add_word(1'b0, 24'h0F0F, 16);
      add_word(1'b1, 24'hF0F0, 16);
      add_word(1'b0, 24'h3C3C, 16);
      add_word(1'b1, 24'hC3C3, 16);
      push_pair(16'h3C3C, 16'hC3C3);
      base_v = valid_seen;
      base_e = err_seen;
      send_range(0, 6);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_left", 32'(left_sample), 32'h0);
      check("mid_rst_right", 32'(right_sample), 32'h0);
      check("mid_rst_valid", 32'(sample_valid), 32'h0);
      check("mid_rst_frame_err", 32'(frame_err), 32'h0);
      check("mid_rst_locked", 32'(locked), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      send_range(6, ch_q.size());
      repeat (10) @(negedge clk);
      check("mid_rst_valid_count", 32'(valid_seen - base_v), 32'd1);
      check("mid_rst_frame_err_count", 32'(err_seen - base_e), 32'd0);
      check("mid_rst_pairs_pending", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
